// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for a LEGv8 core sharing one
// instruction/data memory; req/ack memory handshake with timeout and a retire counter.
module multicycle_sequencer #(
  parameter int MAX_WAIT = 15,
  parameter int COUNT_W  = 32
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [10:0]        opcode,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg2loc,
  output logic               alusrc,
  output logic               mem2reg,
  output logic               regwrite,
  output logic [3:0]         aluop,
  output logic [1:0]         signop,
  output logic               fault,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE, CL_ADD, CL_SUB, CL_AND, CL_ORR, CL_ADDI, CL_SUBI,
    CL_LDUR, CL_STUR, CL_CBZ, CL_B, CL_UNSUP
  } class_e;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SIGN_B  = 2'b00;
  localparam logic [1:0] SIGN_CB = 2'b01;
  localparam logic [1:0] SIGN_I  = 2'b10;
  localparam logic [1:0] SIGN_D  = 2'b11;

  localparam int              WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  state_e               state_q, state_d;
  class_e               class_q, class_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [COUNT_W-1:0]   instr_count_q, instr_count_d;

  class_e               dec_class;
  logic                 cls_reg2loc;
  logic                 cls_alusrc;
  logic [3:0]           cls_aluop;
  logic [1:0]           cls_signop;

  always_comb begin
    dec_class = CL_UNSUP;
    casez (opcode)
      11'b?0?01011???: dec_class = CL_ADD;
      11'b?1?01011???: dec_class = CL_SUB;
      11'b?0001010???: dec_class = CL_AND;
      11'b?0101010???: dec_class = CL_ORR;
      11'b?0?10001???: dec_class = CL_ADDI;
      11'b?1?10001???: dec_class = CL_SUBI;
      11'b??111000010: dec_class = CL_LDUR;
      11'b??111000000: dec_class = CL_STUR;
      11'b?011010????: dec_class = CL_CBZ;
      11'b?00101?????: dec_class = CL_B;
      default:         dec_class = CL_UNSUP;
    endcase
  end

  // Datapath fields of the latched class; shared by EXEC, MEM and WB so they stay stable.
  always_comb begin
    cls_reg2loc = 1'b0;
    cls_alusrc  = 1'b0;
    cls_aluop   = ALU_AND;
    cls_signop  = SIGN_B;
    case (class_q)
      CL_ADD:  cls_aluop = ALU_ADD;
      CL_SUB:  cls_aluop = ALU_SUB;
      CL_AND:  cls_aluop = ALU_AND;
      CL_ORR:  cls_aluop = ALU_ORR;
      CL_ADDI: begin cls_alusrc = 1'b1; cls_signop = SIGN_I; cls_aluop = ALU_ADD; end
      CL_SUBI: begin cls_alusrc = 1'b1; cls_signop = SIGN_I; cls_aluop = ALU_SUB; end
      CL_LDUR: begin cls_alusrc = 1'b1; cls_signop = SIGN_D; cls_aluop = ALU_ADD; end
      CL_STUR: begin
        cls_alusrc  = 1'b1;
        cls_signop  = SIGN_D;
        cls_aluop   = ALU_ADD;
        cls_reg2loc = 1'b1;
      end
      CL_CBZ:  begin cls_reg2loc = 1'b1; cls_aluop = ALU_PASSB; cls_signop = SIGN_CB; end
      default: cls_signop = SIGN_B;
    endcase
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default here so no path infers a latch.
    state_d    = state_q;
    class_d    = class_q;
    wait_cnt_d = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alusrc     = 1'b0;
    mem2reg    = 1'b0;
    regwrite   = 1'b0;
    aluop      = '0;
    signop     = '0;

    // Outputs are gated by reset so strobes drop the instant resetl falls.
    if (resetl) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_write = 1'b1;
            state_d  = S_DECODE;
          end else if (wait_cnt_q == WAIT_LIM) begin
            state_d = S_FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end

        S_DECODE: begin
          class_d = dec_class;
          state_d = (dec_class == CL_UNSUP) ? S_FAULT : S_EXEC;
        end

        S_EXEC: begin
          reg2loc = cls_reg2loc;
          alusrc  = cls_alusrc;
          aluop   = cls_aluop;
          signop  = cls_signop;
          case (class_q)
            CL_CBZ: begin
              pc_write = 1'b1;
              pc_src   = zero;
              state_d  = S_FETCH;
            end
            CL_B: begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
              state_d  = S_FETCH;
            end
            CL_LDUR, CL_STUR:                          state_d = S_MEM;
            CL_ADD, CL_SUB, CL_AND, CL_ORR,
            CL_ADDI, CL_SUBI:                          state_d = S_WB;
            default:                                   state_d = S_FAULT;
          endcase
        end

        S_MEM: begin
          reg2loc = cls_reg2loc;
          alusrc  = cls_alusrc;
          aluop   = cls_aluop;
          signop  = cls_signop;
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (class_q == CL_STUR);
          if (mem_ack) begin
            if (class_q == CL_STUR) begin
              pc_write = 1'b1;
              state_d  = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (wait_cnt_q == WAIT_LIM) begin
            state_d = S_FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end

        S_WB: begin
          reg2loc  = cls_reg2loc;
          alusrc   = cls_alusrc;
          aluop    = cls_aluop;
          signop   = cls_signop;
          regwrite = 1'b1;
          mem2reg  = (class_q == CL_LDUR);
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end

        S_FAULT: state_d = S_FAULT;
        default: state_d = S_FAULT;
      endcase
    end
  end

  assign instr_count_d = pc_write ? instr_count_q + 1'b1 : instr_count_q;

  always_ff @(posedge CLK or negedge resetl) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetl) begin
      state_q       <= S_FETCH;
      class_q       <= CL_NONE;
      wait_cnt_q    <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      class_q       <= class_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = state_q;
  assign fault       = (state_q == S_FAULT);
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios plus randomized
// instruction streams compared cycle-by-cycle against a per-instruction schedule model.
module tb_multicycle_sequencer;

  localparam int MAX_WAIT = 4;
  localparam int COUNT_W  = 4;
  localparam logic [10:0] MOVZ_OPC = 11'b11010010100;

  typedef enum int {
    C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI, C_LDUR, C_STUR, C_CBZ, C_B, C_BAD
  } icls_e;

  typedef struct packed {
    logic [2:0] state;
    logic       fault;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg2loc;
    logic       alusrc;
    logic       mem2reg;
    logic       regwrite;
    logic [3:0] aluop;
    logic [1:0] signop;
  } obs_t;

  logic               CLK;
  logic               resetl;
  logic [10:0]        opcode;
  logic               zero;
  logic               mem_ack;
  logic               mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic               reg2loc, alusrc, mem2reg, regwrite, fault;
  logic [3:0]         aluop;
  logic [1:0]         signop;
  logic [2:0]         state;
  logic [COUNT_W-1:0] instr_count;

  logic [COUNT_W-1:0] model_cnt;
  int                 n_checks = 0;
  int                 n_pass   = 0;

  multicycle_sequencer #(.MAX_WAIT(MAX_WAIT), .COUNT_W(COUNT_W)) dut (
    .CLK        (CLK),
    .resetl     (resetl),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg2loc    (reg2loc),
    .alusrc     (alusrc),
    .mem2reg    (mem2reg),
    .regwrite   (regwrite),
    .aluop      (aluop),
    .signop     (signop),
    .fault      (fault),
    .state      (state),
    .instr_count(instr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic obs_t observe();
    obs_t o;
    o.state    = state;
    o.fault    = fault;
    o.mem_req  = mem_req;
    o.mem_we   = mem_we;
    o.iord     = iord;
    o.ir_write = ir_write;
    o.pc_write = pc_write;
    o.pc_src   = pc_src;
    o.reg2loc  = reg2loc;
    o.alusrc   = alusrc;
    o.mem2reg  = mem2reg;
    o.regwrite = regwrite;
    o.aluop    = aluop;
    o.signop   = signop;
    return o;
  endfunction

  // Random opcode of a class: fixed bits from the class pattern, don't-care bits random.
  function automatic logic [10:0] opc_for(input icls_e c);
    logic [10:0] m, v, r;
    r = 11'($urandom);
    case (c)
      C_ADD:   begin m = 11'b01011111000; v = 11'b00001011000; end
      C_SUB:   begin m = 11'b01011111000; v = 11'b01001011000; end
      C_AND:   begin m = 11'b01111111000; v = 11'b00001010000; end
      C_ORR:   begin m = 11'b01111111000; v = 11'b00101010000; end
      C_ADDI:  begin m = 11'b01011111000; v = 11'b00010001000; end
      C_SUBI:  begin m = 11'b01011111000; v = 11'b01010001000; end
      C_LDUR:  begin m = 11'b00111111111; v = 11'b00111000010; end
      C_STUR:  begin m = 11'b00111111111; v = 11'b00111000000; end
      C_CBZ:   begin m = 11'b01111110000; v = 11'b00110100000; end
      C_B:     begin m = 11'b01111100000; v = 11'b00010100000; end
      default: begin m = 11'b11111111111; v = MOVZ_OPC;       end
    endcase
    return (r & ~m) | (v & m);
  endfunction

  // Datapath fields the datapath needs for each instruction class.
  function automatic obs_t class_fields(input icls_e c);
    obs_t o;
    o = obs_t'(0);
    case (c)
      C_ADD:  o.aluop = 4'b0010;
      C_SUB:  o.aluop = 4'b0110;
      C_AND:  o.aluop = 4'b0000;
      C_ORR:  o.aluop = 4'b0001;
      C_ADDI: begin o.alusrc = 1'b1; o.signop = 2'b10; o.aluop = 4'b0010; end
      C_SUBI: begin o.alusrc = 1'b1; o.signop = 2'b10; o.aluop = 4'b0110; end
      C_LDUR: begin o.alusrc = 1'b1; o.signop = 2'b11; o.aluop = 4'b0010; end
      C_STUR: begin
        o.alusrc = 1'b1; o.signop = 2'b11; o.aluop = 4'b0010; o.reg2loc = 1'b1;
      end
      C_CBZ:  begin o.reg2loc = 1'b1; o.aluop = 4'b0111; o.signop = 2'b01; end
      default: o.signop = 2'b00;
    endcase
    return o;
  endfunction

  task automatic check_obs(input string tag, input obs_t exp);
    obs_t act;
    act = observe();
    n_checks++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, act, exp);
  endtask

  task automatic check_count(input string tag);
    n_checks++;
    assert (instr_count === model_cnt) n_pass++;
    else $error("FAIL %s: instr_count observed %0d expected %0d", tag, instr_count, model_cnt);
  endtask

  // One clock cycle starting at a falling edge: drive inputs, check, advance.
  task automatic cycle(input string tag, input obs_t exp, input logic ack, input logic z);
    mem_ack = ack;
    zero    = z;
    #1 check_obs(tag, exp);
    if (exp.pc_write) model_cnt = model_cnt + 1'b1;
    @(negedge CLK);
  endtask

  task automatic fault_phase(input string tag, input int n);
    obs_t e;
    e = obs_t'(0);
    e.state = 3'd7;
    e.fault = 1'b1;
    for (int i = 0; i < n; i++) begin
      opcode = 11'($urandom);
      cycle({tag, "/fault"}, e, 1'($urandom), 1'($urandom));
    end
    check_count({tag, "/fault_cnt"});
  endtask

  task automatic do_reset(input string tag);
    #2 resetl = 1'b0;
    #1 check_obs({tag, "/rst"}, obs_t'(0));
    model_cnt = '0;
    check_count({tag, "/rst_cnt"});
    @(negedge CLK);
    resetl = 1'b1;
  endtask

  // Drives one instruction: fw/mw = wait cycles before the fetch/data ack (> MAX_WAIT times out).
  task automatic do_instr(input string tag, input icls_e c, input logic [10:0] opc,
                          input int fw, input int mw, input logic z);
    obs_t e, f;
    f = class_fields(c);

    for (int i = 0; i <= fw && i <= MAX_WAIT; i++) begin
      e = obs_t'(0);
      e.state   = 3'd0;
      e.mem_req = 1'b1;
      if (i == fw) begin
        e.ir_write = 1'b1;
        opcode     = opc;
      end else begin
        opcode = 11'($urandom);
      end
      cycle({tag, "/fetch"}, e, (i == fw), 1'($urandom));
    end
    if (fw > MAX_WAIT) begin
      fault_phase(tag, 20);
      return;
    end

    e = obs_t'(0);
    e.state = 3'd1;
    cycle({tag, "/decode"}, e, 1'($urandom), 1'($urandom));
    if (c == C_BAD) begin
      fault_phase(tag, 20);
      return;
    end
    opcode = 11'($urandom);

    e = f;
    e.state = 3'd2;
    if (c == C_CBZ) begin e.pc_write = 1'b1; e.pc_src = z;    end
    if (c == C_B)   begin e.pc_write = 1'b1; e.pc_src = 1'b1; end
    cycle({tag, "/exec"}, e, 1'($urandom), (c == C_CBZ) ? z : 1'($urandom));
    if (c == C_CBZ || c == C_B) begin
      check_count({tag, "/cnt"});
      return;
    end

    if (c == C_LDUR || c == C_STUR) begin
      for (int i = 0; i <= mw && i <= MAX_WAIT; i++) begin
        e = f;
        e.state   = 3'd3;
        e.mem_req = 1'b1;
        e.iord    = 1'b1;
        e.mem_we  = (c == C_STUR);
        if (i == mw && c == C_STUR) e.pc_write = 1'b1;
        cycle({tag, "/mem"}, e, (i == mw), 1'($urandom));
      end
      if (mw > MAX_WAIT) begin
        fault_phase(tag, 20);
        return;
      end
      if (c == C_STUR) begin
        check_count({tag, "/cnt"});
        return;
      end
    end

    e = f;
    e.state    = 3'd4;
    e.regwrite = 1'b1;
    e.mem2reg  = (c == C_LDUR);
    e.pc_write = 1'b1;
    cycle({tag, "/wb"}, e, 1'($urandom), 1'($urandom));
    check_count({tag, "/cnt"});
  endtask

  initial begin
    obs_t e;
    icls_e rc;
    resetl    = 1'b1;
    mem_ack   = 1'b0;
    zero      = 1'b0;
    opcode    = '0;
    model_cnt = '0;

    #1 resetl = 1'b0;
    #2 check_obs("reset", obs_t'(0));
    check_count("reset_cnt");
    @(negedge CLK);
    resetl = 1'b1;

    do_instr("add",    C_ADD,  11'b10001011000, 0, 0, 1'b0);
    do_instr("ldur",   C_LDUR, 11'b11111000010, 0, 3, 1'b0);
    do_instr("cbz_t",  C_CBZ,  11'b10110100101, 0, 0, 1'b1);
    do_instr("cbz_nt", C_CBZ,  11'b10110100011, 1, 0, 1'b0);
    do_instr("b",      C_B,    opc_for(C_B),    2, 0, 1'b0);
    do_instr("stur",   C_STUR, opc_for(C_STUR), 2, 1, 1'b0);
    do_instr("sub",    C_SUB,  opc_for(C_SUB),  0, 0, 1'b0);
    do_instr("and",    C_AND,  opc_for(C_AND),  MAX_WAIT, 0, 1'b0);
    do_instr("orr",    C_ORR,  opc_for(C_ORR),  0, 0, 1'b0);
    do_instr("addi",   C_ADDI, opc_for(C_ADDI), 0, 0, 1'b0);
    do_instr("subi",   C_SUBI, opc_for(C_SUBI), 0, 0, 1'b0);

    do_instr("movz", C_BAD, MOVZ_OPC, 0, 0, 1'b0);
    do_reset("movz");

    do_instr("add_pre", C_ADD, opc_for(C_ADD), 0, 0, 1'b0);
    do_instr("fetch_to", C_ADD, opc_for(C_ADD), MAX_WAIT + 1, 0, 1'b0);
    do_reset("fetch_to");

    do_instr("mem_to", C_LDUR, opc_for(C_LDUR), 0, MAX_WAIT + 1, 1'b0);
    do_reset("mem_to");

    // STUR interrupted by reset while waiting for the data ack.
    do_instr("pre_stur", C_B, opc_for(C_B), 0, 0, 1'b0);
    e = obs_t'(0); e.state = 3'd0; e.mem_req = 1'b1; e.ir_write = 1'b1;
    opcode = opc_for(C_STUR);
    cycle("stur_rst/fetch", e, 1'b1, 1'b0);
    e = obs_t'(0); e.state = 3'd1;
    cycle("stur_rst/decode", e, 1'b0, 1'b0);
    e = class_fields(C_STUR); e.state = 3'd2;
    cycle("stur_rst/exec", e, 1'b0, 1'b0);
    e = class_fields(C_STUR); e.state = 3'd3; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1;
    cycle("stur_rst/mem0", e, 1'b0, 1'b0);
    cycle("stur_rst/mem1", e, 1'b0, 1'b0);
    do_reset("stur_rst");
    do_instr("post_rst", C_ADD, opc_for(C_ADD), 0, 0, 1'b0);

    // Random instruction stream; enough retires to wrap the narrow counter.
    for (int k = 0; k < 40; k++) begin
      rc = icls_e'($urandom_range(0, 9));
      do_instr($sformatf("rnd%0d", k), rc, opc_for(rc),
               $urandom_range(0, MAX_WAIT), $urandom_range(0, MAX_WAIT), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
